bcd_to_fnd: RTL and testbench
=============================

// Module: bcd_to_fnd
// PURPOSE
//   Registered BCD-to-7-segment (FND) driver for a 4-digit common-anode display.
//   Decodes one 4-bit value into a segment font and asserts one digit-enable line.
//   Sits between the display-scan multiplexer (digit select and value) and the board FND pins.
//   A global enable blanks the whole display.
// PARAMETERS
//   HEX_EN      0  1: values 10-15 show hex glyphs A,b,C,d,E,F; 0: values 10-15 blank
//   ACTIVE_LOW  1  1: digit and segment outputs active-low (common anode); 0: all outputs inverted
// PORTS
//   i_clk            in   1  system clock, rising edge
//   i_reset          in   1  asynchronous, active-high reset
//   i_En             in   1  display enable; 0 blanks all digits and segments
//   i_DigitSelect    in   2  digit to light, 0 = rightmost .. 3 = leftmost
//   i_Value          in   4  BCD value for the selected digit
//   o_FND_Digit      out  4  digit enables, bit n = digit n
//   o_FND_Font       out  8  segments {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high.
//   - Values below are for ACTIVE_LOW=1. With ACTIVE_LOW=0, every output bit is inverted.
//   - Reset (async, while i_reset=1):
//     - o_FND_Digit = 4'b1111 (all off)
//     - o_FND_Font  = 8'hFF (all off)
//     - Outputs hold these values until the first rising edge after i_reset deasserts.
//   - Both outputs are registered. Latency is 1 cycle: inputs sampled at edge k appear after edge k.
//     No combinational path from inputs to outputs.
//   - Enabled (i_En=1):
//     - o_FND_Digit = ~(4'b0001 << i_DigitSelect): 00->1110, 01->1101, 10->1011, 11->0111.
//     - Exactly one digit is low at any time.
//   - Font table, dp always off (bit7=1):
//     - 0=C0  1=F9  2=A4  3=B0  4=99
//     - 5=92  6=82  7=F8  8=80  9=90
//   - Values 10-15:
//     - HEX_EN=1: A=88 b=83 C=C6 d=A1 E=86 F=8E
//     - HEX_EN=0: font 8'hFF (blank); the digit line is still driven as selected.
//   - Disabled (i_En=0): o_FND_Digit=4'b1111 and o_FND_Font=8'hFF, regardless of i_DigitSelect and i_Value.
//   - i_En has no priority over reset. Reset wins whenever asserted, including mid-operation.
//   - X or Z on the inputs need not be handled. No other state exists: the block is a pure registered decoder.
// TESTING
//   1. Reset: assert i_reset with arbitrary inputs -> outputs 4'b1111 / 8'hFF immediately, without a clock edge.
//      Release i_reset -> outputs unchanged until the next edge.
//   2. Enabled sweep: i_En=1, (sel,val) = (0,0),(1,1),(2,2),(3,3),(0,4),(1,5),(2,6),(3,7),(0,8),(1,9).
//      Fonts one cycle later: C0,F9,A4,B0,99,92,82,F8,80,90. Digits: 1110,1101,1011,0111 repeating.
//   3. Non-BCD input: i_En=1, sel=2, val=4'hA.
//      HEX_EN=0 -> digit 1011, font FF. HEX_EN=1 -> digit 1011, font 88.
//   4. Disabled sweep: i_En=0 with the same 11 (sel,val) pairs as tests 2 and 3 -> every cycle 1111 / FF.
//   5. Latency: toggle i_Value 3->8 between edges -> o_FND_Font changes B0->80 only at the next rising edge.
//   6. Mid-run reset: assert i_reset asynchronously while showing (sel=1,val=5) -> outputs go to 1111 / FF at once.
//      After release, the first edge restores digit 1101 and font 92.

Source files
------------

// File: rtl/bcd_to_fnd.sv
// Registered BCD-to-7-segment driver for a 4-digit common-anode FND.
// One value is decoded into a segment font and one digit line is asserted.
// Both outputs come straight from flops, so there is exactly one cycle of
// latency and no combinational path from inputs to pins.
// The font and digit logic is built in active-low form (1 = off). A final
// XOR mask flips every bit when ACTIVE_LOW=0, and that includes the reset values.
module bcd_to_fnd #(
  parameter bit HEX_EN     = 1'b0,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_En,
  input  logic [1:0] i_DigitSelect,
  input  logic [3:0] i_Value,
  output logic [3:0] o_FND_Digit,
  output logic [7:0] o_FND_Font
);

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] DIG_POL    = ACTIVE_LOW ? 4'h0  : 4'hF;
  localparam logic [7:0] FONT_POL   = ACTIVE_LOW ? 8'h00 : 8'hFF;
  localparam logic [3:0] DIG_OFF    = 4'hF;
  localparam logic [7:0] FONT_OFF   = 8'hFF;

  // Scan request as seen on the inputs this cycle.
  typedef struct packed {
    logic       en;
    logic [1:0] sel;
    logic [3:0] val;
  } scan_req_t;

  scan_req_t  req;
  logic [NUM_DIGITS-1:0] dig_on;
  logic [3:0] digit_nxt;
  logic [7:0] font_nxt;

  assign req = '{en: i_En, sel: i_DigitSelect, val: i_Value};

  // Active-low font lookup {dp,g,f,e,d,c,b,a}; the dp segment is always off.
  function automatic logic [7:0] font_lut(input logic [3:0] v);
    logic [7:0] f;
    case (v)
      4'h0: f = 8'hC0;
      4'h1: f = 8'hF9;
      4'h2: f = 8'hA4;
      4'h3: f = 8'hB0;
      4'h4: f = 8'h99;
      4'h5: f = 8'h92;
      4'h6: f = 8'h82;
      4'h7: f = 8'hF8;
      4'h8: f = 8'h80;
      4'h9: f = 8'h90;
      4'hA: f = HEX_EN ? 8'h88 : FONT_OFF;
      4'hB: f = HEX_EN ? 8'h83 : FONT_OFF;
      4'hC: f = HEX_EN ? 8'hC6 : FONT_OFF;
      4'hD: f = HEX_EN ? 8'hA1 : FONT_OFF;
      4'hE: f = HEX_EN ? 8'h86 : FONT_OFF;
      default: f = HEX_EN ? 8'h8E : FONT_OFF;
    endcase
    return f;
  endfunction

  // Per-digit enable: a digit lights only when it is selected and the display is enabled.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign dig_on[g] = req.en && (req.sel == 2'(g));
  end

  // Next-state decode, converted to the output polarity.
  always_comb begin
    digit_nxt = ~dig_on ^ DIG_POL;
    font_nxt  = (req.en ? font_lut(req.val) : FONT_OFF) ^ FONT_POL;
  end

  // Output registers; reset blanks the display asynchronously and takes priority over enable.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_FND_Digit <= DIG_OFF ^ DIG_POL;
      o_FND_Font  <= FONT_OFF ^ FONT_POL;
    end else begin
      o_FND_Digit <= digit_nxt;
      o_FND_Font  <= font_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_to_fnd.sv
// Directed bench for bcd_to_fnd. Three instances share the same stimulus:
//   d0: HEX_EN=0, ACTIVE_LOW=1
//   d1: HEX_EN=1, ACTIVE_LOW=1
//   d2: HEX_EN=1, ACTIVE_LOW=0 (every bit is the inverse of d1)
module tb_bcd_to_fnd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] val = 4'd0;
  logic [3:0] dig0, dig1, dig2;
  logic [7:0] fnt0, fnt1, fnt2;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  bcd_to_fnd #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b1)) d0 (
    .i_clk(clk), .i_reset(rst), .i_En(en), .i_DigitSelect(sel), .i_Value(val),
    .o_FND_Digit(dig0), .o_FND_Font(fnt0));
  bcd_to_fnd #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b1)) d1 (
    .i_clk(clk), .i_reset(rst), .i_En(en), .i_DigitSelect(sel), .i_Value(val),
    .o_FND_Digit(dig1), .o_FND_Font(fnt1));
  bcd_to_fnd #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b0)) d2 (
    .i_clk(clk), .i_reset(rst), .i_En(en), .i_DigitSelect(sel), .i_Value(val),
    .o_FND_Digit(dig2), .o_FND_Font(fnt2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all three instances against one expected (digit, font-without-hex, font-with-hex).
  task automatic chk_all(input string tag, input logic [3:0] ed,
                         input logic [7:0] ef0, input logic [7:0] ef1);
    chk({tag, " d0.dig"}, {4'h0, dig0}, {4'h0, ed});
    chk({tag, " d0.fnt"}, fnt0, ef0);
    chk({tag, " d1.dig"}, {4'h0, dig1}, {4'h0, ed});
    chk({tag, " d1.fnt"}, fnt1, ef1);
    chk({tag, " d2.dig"}, {4'h0, dig2}, {4'h0, ~ed});
    chk({tag, " d2.fnt"}, fnt2, ~ef1);
  endtask

  // Drive one vector mid-cycle, then check 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic e, input logic [1:0] s, input logic [3:0] v,
                      input logic [3:0] ed, input logic [7:0] ef0, input logic [7:0] ef1);
    @(negedge clk);
    en = e; sel = s; val = v;
    @(posedge clk);
    #1;
    chk_all(tag, ed, ef0, ef1);
  endtask

  logic [1:0] sw_sel [11] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [3:0] sw_val [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'hA};
  logic [3:0] sw_dig [11] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101,
                              4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011};
  logic [7:0] sw_f0  [11] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                              8'h82, 8'hF8, 8'h80, 8'h90, 8'hFF};
  logic [7:0] sw_f1  [11] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                              8'h82, 8'hF8, 8'h80, 8'h90, 8'h88};

  initial begin
    // Reset asserts with arbitrary inputs and no clock edge in between.
    en = 1'b1; sel = 2'd2; val = 4'd7;
    #2 rst = 1'b1;
    #1 chk_all("rst_async", 4'b1111, 8'hFF, 8'hFF);
    @(posedge clk); #1;
    chk_all("rst_hold", 4'b1111, 8'hFF, 8'hFF);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; sel = 2'd1; val = 4'd5;
    #1 chk_all("rst_release", 4'b1111, 8'hFF, 8'hFF);
    @(posedge clk); #1;
    chk_all("rst_first_edge", 4'b1101, 8'h92, 8'h92);

    // Enabled sweep, including the first non-BCD value.
    for (int i = 0; i < 11; i++)
      step($sformatf("en_sweep%0d", i), 1'b1, sw_sel[i], sw_val[i], sw_dig[i], sw_f0[i], sw_f1[i]);

    // Remaining hex glyphs.
    step("hex_b", 1'b1, 2'd1, 4'hB, 4'b1101, 8'hFF, 8'h83);
    step("hex_c", 1'b1, 2'd0, 4'hC, 4'b1110, 8'hFF, 8'hC6);
    step("hex_d", 1'b1, 2'd3, 4'hD, 4'b0111, 8'hFF, 8'hA1);
    step("hex_e", 1'b1, 2'd2, 4'hE, 4'b1011, 8'hFF, 8'h86);
    step("hex_f", 1'b1, 2'd3, 4'hF, 4'b0111, 8'hFF, 8'h8E);

    // Disabled sweep: always blank.
    for (int i = 0; i < 11; i++)
      step($sformatf("dis_sweep%0d", i), 1'b0, sw_sel[i], sw_val[i], 4'b1111, 8'hFF, 8'hFF);

    // Latency: input change between edges shows only at the next edge.
    step("lat_pre", 1'b1, 2'd3, 4'd3, 4'b0111, 8'hB0, 8'hB0);
    #1 val = 4'd8;
    #1 chk_all("lat_between", 4'b0111, 8'hB0, 8'hB0);
    @(posedge clk); #1;
    chk_all("lat_after", 4'b0111, 8'h80, 8'h80);

    // Mid-run reset while showing digit 1 value 5.
    step("mid_pre", 1'b1, 2'd1, 4'd5, 4'b1101, 8'h92, 8'h92);
    #1 rst = 1'b1;
    #1 chk_all("mid_rst", 4'b1111, 8'hFF, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_all("mid_release", 4'b1111, 8'hFF, 8'hFF);
    @(posedge clk); #1;
    chk_all("mid_restore", 4'b1101, 8'h92, 8'h92);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
